seg_scan_driver: RTL
====================

# seg_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the up/down counter and takes a 16-bit value (four hex nibbles) plus per-digit decimal points. It scans one digit at a time, holding each digit for a programmable refresh period with an anti-ghosting blank window, and drives the active-low `anodes` and `segments` pins. The displayed value is snapshotted once per frame so that a digit never shows a torn mid-frame update.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit period; must be ≥ 2.
- `BLANK_CYCLES`, default 16: cycles at the start of each digit period with all anodes off; must be < `REFRESH_DIV`.
- `clk`, input, 1: system clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `value`, input, 16: nibble i (`value[4i+3:4i]`) is shown on digit i.
- `dp_in`, input, 4: `dp_in[i]`=1 lights the decimal point of digit i.
- `enable`, input, 1: 0 forces the display dark; scanning continues.
- `anodes`, output, 4: active-low digit select; `anodes[i]` drives digit i.
- `segments`, output, 8: active-low; `[6:0]`={g,f,e,d,c,b,a}, `[7]`=dp.
- `frame_done`, output, 1: one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- State:
  - `tick_cnt`: 0..`REFRESH_DIV`-1.
  - `idx`: 2 bits, the current digit.
  - `snap_val`: 16 bits.
  - `snap_dp`: 4 bits.
- Every cycle:
  - If `tick_cnt`=`REFRESH_DIV`-1: `tick_cnt`←0 and `idx`←`idx`+1 (mod 4, wraps 3→0).
  - Otherwise: `tick_cnt`←`tick_cnt`+1.
- Snapshot: on the edge where `idx` wraps 3→0, `snap_val`←`value` and `snap_dp`←`dp_in`. The same edge sets `frame_done`=1; `frame_done` is 0 on every other cycle.
- Hex decode (dp bit is 1 in every code): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Digit output: the code of nibble `idx` of `snap_val`, with bit 7 cleared if `snap_dp[idx]`=1.
- Outputs are registered. On each edge they load f(current `tick_cnt`, `idx`, snapshot, `enable`):
  - If `enable`=0 or `tick_cnt`<`BLANK_CYCLES`: `anodes`=4'b1111 and `segments`=8'hFF.
  - Otherwise: `anodes`=~(1<<`idx`) and `segments`=digit output.
- Exactly zero or one anode is low at any time.
- Reset, at any point including mid-frame: `tick_cnt`=0, `idx`=0, `snap_val`=0, `snap_dp`=0, `anodes`=4'b1111, `segments`=8'hFF, `frame_done`=0.
- Because `snap_val` resets to 0, frame 0 after reset displays 0000. `value` is first visible in frame 1, after the first wrap.
- `value` and `dp_in` changes between wraps have no effect on the display until the next wrap.
- `enable` does not gate the counters or the snapshot. On re-enable, the display resumes at the current scan position.

## Timing
- Outputs lag state by exactly one cycle.
- Digit period: `REFRESH_DIV` cycles. Frame period: 4×`REFRESH_DIV` cycles.
- After reset deassertion, at state cycle k (`tick_cnt`=k, `idx`=0):
  - `anodes` first goes low at the edge following `tick_cnt`=`BLANK_CYCLES`.
  - It stays low for `REFRESH_DIV`−`BLANK_CYCLES` cycles.
  - It is then high for `BLANK_CYCLES` cycles before the next digit lights.
- `frame_done` is high in the same cycle in which the new snapshot becomes state.
- The new snapshot reaches the pins at the first lit cycle of digit 0.
- The nominal defaults are 100 MHz, 1 kHz per digit and a 250 Hz frame rate.

## Configuration
- Macro: `SEG_SCAN_LZB_EN` (leading-zero blanking).
- Defined: digit i>0 is suppressed (anode stays high, `segments`=8'hFF for its whole lit window) when all of these hold:
  - `snap_val` nibbles i..3 are all zero.
  - `snap_dp[i]`=0.
- Digit 0 is never suppressed, so a value of 0 shows a single "0".
- Not defined: all four digits are always shown, including leading zeros.

## Test plan
All scenarios use `REFRESH_DIV`=8 and `BLANK_CYCLES`=2.
- Reset released, `enable`=1, `value`=16'h1234 → frame 0 lights `anodes` 1110, 1101, 1011, 0111 in turn, each with `segments`=C0. `frame_done` pulses at cycle 32. Frame 1 shows 4 (99) on digit 0, 3 (B0) on digit 1, 2 (A4) on digit 2 and 1 (F9) on digit 3. Each digit has 6 lit cycles and 2 blank cycles.
- `value` changes from 16'h1234 to 16'hABCD while digit 2 is lit → the rest of the frame still shows 1234; the next frame shows D (A1), C (C6), b (83), A (88).
- `dp_in`=4'b0100 with `value`=16'h0000 → digit 2 shows `segments`=8'h40; the other digits show C0.
- `enable` low for 20 cycles mid-frame → `anodes`=1111 and `segments`=FF one cycle after `enable` falls. `frame_done` timing is unchanged. The display resumes at the current `idx`.
- `reset` asserted while digit 3 is lit → `anodes`=1111 and `segments`=FF immediately, without waiting for a clock edge. The scan restarts at digit 0 showing 0.
- With `SEG_SCAN_LZB_EN`, `value`=16'h0070 → digits 3 and 2 stay dark; digit 1 shows F8 and digit 0 shows C0. With `value`=0, only digit 0 lights.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// Signal bundle between the counter-side source and the 4-digit seven-segment scan driver.
// The master drives value/dp_in/enable; the slave (the driver) returns the display pins.
interface seg_scan_driver_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        enable;
    logic [3:0]  anodes;
    logic [7:0]  segments;
    logic        frame_done;

    modport master (
        output value, dp_in, enable,
        input  anodes, segments, frame_done
    );

    modport slave (
        input  value, dp_in, enable,
        output anodes, segments, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 4-digit seven-segment driver with per-frame value snapshot.
// Optional leading-zero blanking is built when the macro SEG_SCAN_LZB_EN is defined.
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    seg_scan_driver_if.slave bus
);
    localparam int              CW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   TICK_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_LIM = CW'(BLANK_CYCLES);

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = 8'hC0;
            4'h1:    code = 8'hF9;
            4'h2:    code = 8'hA4;
            4'h3:    code = 8'hB0;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h92;
            4'h6:    code = 8'h82;
            4'h7:    code = 8'hF8;
            4'h8:    code = 8'h80;
            4'h9:    code = 8'h90;
            4'hA:    code = 8'h88;
            4'hB:    code = 8'h83;
            4'hC:    code = 8'hC6;
            4'hD:    code = 8'hA1;
            4'hE:    code = 8'h86;
            4'hF:    code = 8'h8E;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    logic [CW-1:0] tick_q, tick_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_val_q, snap_val_d;
    logic [3:0]    snap_dp_q, snap_dp_d;
    logic [3:0]    anodes_q, anodes_d;
    logic [7:0]    segments_q, segments_d;
    logic          frame_done_q, frame_done_d;

    logic          wrap_s;
    logic [3:0]    nib_s;
    logic          suppress_s;
    logic          lit_s;

    assign wrap_s = (tick_q == TICK_MAX) && (idx_q == 2'd3);

    // Scan position, per-frame snapshot and frame pulse next-state
    always_comb begin
        tick_d       = tick_q;
        idx_d        = idx_q;
        snap_val_d   = snap_val_q;
        snap_dp_d    = snap_dp_q;
        frame_done_d = 1'b0;
        if (tick_q == TICK_MAX) begin
            tick_d = '0;
            idx_d  = idx_q + 2'd1;
        end else begin
            tick_d = tick_q + CW'(1);
        end
        if (wrap_s) begin
            snap_val_d   = bus.value;
            snap_dp_d    = bus.dp_in;
            frame_done_d = 1'b1;
        end else begin
            frame_done_d = 1'b0;
        end
    end

    // Select the nibble of the snapshot belonging to the current digit
    always_comb begin
        nib_s = 4'h0;
        case (idx_q)
            2'd0:    nib_s = snap_val_q[3:0];
            2'd1:    nib_s = snap_val_q[7:4];
            2'd2:    nib_s = snap_val_q[11:8];
            2'd3:    nib_s = snap_val_q[15:12];
            default: nib_s = 4'h0;
        endcase
    end

`ifdef SEG_SCAN_LZB_EN
    // A digit is a leading zero when it and every higher nibble are zero and its dp is off
    always_comb begin
        suppress_s = 1'b0;
        case (idx_q)
            2'd1:    suppress_s = (snap_val_q[15:4]  == 12'h000) && !snap_dp_q[1];
            2'd2:    suppress_s = (snap_val_q[15:8]  == 8'h00)   && !snap_dp_q[2];
            2'd3:    suppress_s = (snap_val_q[15:12] == 4'h0)    && !snap_dp_q[3];
            default: suppress_s = 1'b0;
        endcase
    end
`else
    assign suppress_s = 1'b0;
`endif

    assign lit_s = bus.enable && (tick_q >= BLANK_LIM) && !suppress_s;

    // Pin values for the next cycle, computed from the present scan state
    always_comb begin
        anodes_d   = 4'b1111;
        segments_d = 8'hFF;
        if (lit_s) begin
            anodes_d   = ~(4'b0001 << idx_q);
            segments_d = hex_to_seg(nib_s) & ~{snap_dp_q[idx_q], 7'b000_0000};
        end else begin
            anodes_d   = 4'b1111;
            segments_d = 8'hFF;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q       <= '0;
            idx_q        <= 2'd0;
            snap_val_q   <= 16'h0000;
            snap_dp_q    <= 4'h0;
            anodes_q     <= 4'b1111;
            segments_q   <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            snap_val_q   <= snap_val_d;
            snap_dp_q    <= snap_dp_d;
            anodes_q     <= anodes_d;
            segments_q   <= segments_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.anodes     = anodes_q;
    assign bus.segments   = segments_q;
    assign bus.frame_done = frame_done_q;
endmodule
